// File: rtl/axis_fifo_if.sv
// rtl/axis_fifo_if.sv - AXI-Stream beat interface with master/slave modports
interface axis_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
) ();
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [USER_WIDTH-1:0]   user;
    logic                    valid;
    logic                    ready;

    modport master (output data, output keep, output last, output user, output valid, input ready);
    modport slave  (input data, input keep, input last, input user, input valid, output ready);
endinterface

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO, registered outputs, optional store-and-forward (AXIS_FIFO_PKT_MODE_EN)
module axis_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2,
    parameter int DEPTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_fifo_if.slave             s_axis,
    axis_fifo_if.master            m_axis,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + KW + 1 + USER_WIDTH;

    // Beat layout: {data, keep, last, user}; last sits just above user.
    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] in_beat;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [BW-1:0] m_beat_q, m_beat_d;
    logic          full_d, empty_d;
    logic          push, pop;

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          in_pkt_q, in_pkt_d;
    logic          m_last;
    assign m_last = m_beat_q[USER_WIDTH];
`endif

    assign in_beat = {s_axis.data, s_axis.keep, s_axis.last, s_axis.user};
    assign push    = s_axis.valid && s_ready_q;
    assign pop     = m_valid_q && m_axis.ready;

    assign {m_axis.data, m_axis.keep, m_axis.last, m_axis.user} = m_beat_q;
    assign m_axis.valid = m_valid_q;
    assign s_axis.ready = s_ready_q;
    assign count        = count_q;

    // Next-state: pointer advance, occupancy flags and the next head-of-queue beat.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        s_ready_d = !full_d;
        // The beat written this cycle becomes the head only when the queue was
        // (or is about to be) empty; otherwise the head comes from storage.
        if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            m_beat_d = in_beat;
        end else begin
            m_beat_d = mem_q[rd_ptr_d[AW-1:0]];
        end
`ifdef AXIS_FIFO_PKT_MODE_EN
        pkt_cnt_d = pkt_cnt_q + PW'(push && s_axis.last) - PW'(pop && m_last);
        in_pkt_d  = pop ? !m_last : in_pkt_q;
        // A packet may start only once a whole packet is stored, or when the
        // FIFO is full of a single oversize packet that would otherwise deadlock.
        m_valid_d = !empty_d && (in_pkt_d || (pkt_cnt_d != '0) || full_d);
`else
        m_valid_d = !empty_d;
`endif
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_beat_q  <= '0;
`ifdef AXIS_FIFO_PKT_MODE_EN
            pkt_cnt_q <= '0;
            in_pkt_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_beat_q  <= m_beat_d;
`ifdef AXIS_FIFO_PKT_MODE_EN
            pkt_cnt_q <= pkt_cnt_d;
            in_pkt_q  <= in_pkt_d;
`endif
        end
    end

    // Beat storage; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_beat;
        end
    end
endmodule
